// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, instruction class codes and the per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWR   = 4'd4,
    MEMWB   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    UNKNOWN = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  typedef struct packed {
    logic       fetch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       illegal;
  } ctrl_t;

  // Moore control word for a state; fetch marks where IRWrite/NextPC follow MemRdy.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
      end
      DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
      end
      MEMADR: c.alu_src_b = SRCB_IMM;
      MEMRD:  c.adr_src = 1'b1;
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      EXECR: begin
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = 1'b1;
      end
      EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      ALUWB:  c.reg_w = 1'b1;
      BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURES;
        c.branch     = 1'b1;
      end
      UNKNOWN: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running CNT_W-wide event counter with async active-high reset; wraps.
module mc_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM datapath (fetch/decode/exec/mem/wb).
// Optional perf counters CycCnt/InstRet are built only with MC_FSM_PERF_EN.
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemRdy,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             ALUOp,
  output logic             Illegal
`ifdef MC_FSM_PERF_EN
  ,
  output logic [CNT_W-1:0] CycCnt,
  output logic [CNT_W-1:0] InstRet
`endif
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;

  function automatic state_t next_state(state_t s, logic [1:0] op, logic [5:0] funct,
                                        logic rdy);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_DP:   n = funct[5] ? EXECI : EXECR;
          OP_MEM:  n = MEMADR;
          OP_BR:   n = BRANCH;
          default: n = UNKNOWN;
        endcase
      end
      MEMADR:  n = funct[0] ? MEMRD : MEMWR;
      MEMRD:   n = rdy ? MEMWB : MEMRD;
      MEMWR:   n = rdy ? FETCH : MEMWR;
      EXECR:   n = ALUWB;
      EXECI:   n = ALUWB;
      MEMWB:   n = FETCH;
      ALUWB:   n = FETCH;
      BRANCH:  n = FETCH;
      UNKNOWN: n = FETCH;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  always_comb begin
    nxt = next_state(state, Op, Funct, MemRdy);
  end

  // Control word is registered from the next state, so it always matches the
  // current state without a decode stage after the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= state_ctrl(FETCH);
    end else begin
      state <= nxt;
      ctrl  <= state_ctrl(nxt);
    end
  end

  assign IRWrite   = ctrl.fetch & MemRdy;
  assign NextPC    = ctrl.fetch & MemRdy;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign Illegal   = ctrl.illegal;

  // Only Funct[5] (immediate) and Funct[0] (load) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
  localparam int unused_cnt_w = CNT_W;

`ifdef MC_FSM_PERF_EN
  logic retire;

  // An instruction retires on the edge that returns to FETCH; UNKNOWN does not count.
  always_comb begin
    case (state)
      MEMWB, ALUWB, BRANCH: retire = 1'b1;
      MEMWR:                retire = MemRdy;
      default:              retire = 1'b0;
    endcase
  end

  mc_perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (1'b1),
    .count (CycCnt)
  );

  mc_perf_counter #(.CNT_W(CNT_W)) u_inst_ret (
    .clk   (clk),
    .rst   (reset),
    .inc   (retire),
    .count (InstRet)
  );
`endif

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: instruction-level model expands each instruction into
// its expected per-cycle control outputs; plus reset, stall and perf checks.
module tb_mc_main_fsm;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          MemRdy;
  logic          IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
  logic [1:0]    ALUSrcB, ResultSrc;
`ifdef MC_FSM_PERF_EN
  logic [CW-1:0] CycCnt, InstRet;
`endif

  mc_main_fsm #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemRdy    (MemRdy),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal)
`ifdef MC_FSM_PERF_EN
    ,
    .CycCnt    (CycCnt),
    .InstRet   (InstRet)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       adr;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic       regw;
    logic       memw;
    logic       br;
    logic       aluop;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic       rdy;
    exp_t       e;
    string      nm;
  } cyc_t;

  cyc_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc_no = 0;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  exp_t       cur_exp;
  string      cur_nm;
  logic       cmp_en = 1'b0;

  // Expected outputs of one instruction phase, straight from the output table.
  function automatic exp_t ph(string p, logic rdy);
    exp_t e;
    e = '0;
    case (p)
      "FETCH":   begin e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; e.irw = rdy; e.npc = rdy; end
      "DECODE":  begin e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; end
      "MEMADR":  e.asb = 2'b01;
      "MEMRD":   e.adr = 1;
      "MEMWR":   begin e.adr = 1; e.memw = 1; end
      "MEMWB":   begin e.rs = 2'b01; e.regw = 1; end
      "EXECR":   begin e.asb = 2'b00; e.aluop = 1; end
      "EXECI":   begin e.asb = 2'b01; e.aluop = 1; end
      "ALUWB":   e.regw = 1;
      "BRANCH":  begin e.asb = 2'b01; e.rs = 2'b10; e.br = 1; end
      "UNKNOWN": e.ill = 1;
      default:   e = '0;
    endcase
    return e;
  endfunction

  // care=0: MemRdy is irrelevant in this phase, so drive it randomly.
  task automatic push(input string p, input logic rdy, input bit care);
    cyc_t c;
    c.op    = cur_op;
    c.funct = cur_funct;
    c.rdy   = care ? rdy : logic'($urandom_range(0, 1));
    c.e     = ph(p, c.rdy);
    c.nm    = p;
    q.push_back(c);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fstall, input int mstall);
    cur_op    = op;
    cur_funct = funct;
    for (int i = 0; i < fstall; i++) push("FETCH", 1'b0, 1);
    push("FETCH", 1'b1, 1);
    push("DECODE", 1'b0, 0);
    case (op)
      2'b00: begin
        push(funct[5] ? "EXECI" : "EXECR", 1'b0, 0);
        push("ALUWB", 1'b0, 0);
      end
      2'b01: begin
        push("MEMADR", 1'b0, 0);
        if (funct[0]) begin
          for (int i = 0; i < mstall; i++) push("MEMRD", 1'b0, 1);
          push("MEMRD", 1'b1, 1);
          push("MEMWB", 1'b0, 0);
        end else begin
          for (int i = 0; i < mstall; i++) push("MEMWR", 1'b0, 1);
          push("MEMWR", 1'b1, 1);
        end
      end
      2'b10:   push("BRANCH", 1'b0, 0);
      default: push("UNKNOWN", 1'b0, 0);
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c       = q.pop_front();
      Op      = c.op;
      Funct   = c.funct;
      MemRdy  = c.rdy;
      cur_exp = c.e;
      cur_nm  = c.nm;
      cmp_en  = 1'b1;
      @(posedge clk);
      #1;
      cmp_en  = 1'b0;
      cyc_no++;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check($sformatf("cyc%0d_%s", cyc_no, cur_nm),
            32'({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                 RegW, MemW, Branch, ALUOp, Illegal}),
            32'(cur_exp));
    end
  end

  task automatic reset_mid_cycle_checks(input string tag);
    MemRdy = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_AdrSrc"}, 32'(AdrSrc), 32'd0);
    check({tag, "_RegW"}, 32'(RegW), 32'd0);
    check({tag, "_MemW"}, 32'(MemW), 32'd0);
    check({tag, "_ALUSrcB"}, 32'(ALUSrcB), 32'h2);
    check({tag, "_ALUSrcA"}, 32'(ALUSrcA), 32'd1);
    check({tag, "_IRWrite_rdy0"}, 32'(IRWrite), 32'd0);
    MemRdy = 1'b1;
    #1;
    check({tag, "_IRWrite_rdy1"}, 32'(IRWrite), 32'd1);
    MemRdy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    Op     = 2'b00;
    Funct  = 6'd0;
    MemRdy = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ALUSrcA", 32'(ALUSrcA), 32'd1);
    check("rst_ALUSrcB", 32'(ALUSrcB), 32'h2);
    check("rst_ResultSrc", 32'(ResultSrc), 32'h2);
    check("rst_others", 32'({IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp, Illegal}), 32'd0);
    reset = 1'b0;

    run_instr(2'b00, 6'b001000, 0, 0);
    check("len_add", 32'(q.size()), 32'd4);
    run_queue();
    run_instr(2'b00, 6'b101000, 0, 0);
    run_queue();
    run_instr(2'b01, 6'b011001, 2, 3);
    check("len_ldr_stall", 32'(q.size()), 32'd10);
    run_queue();
    run_instr(2'b01, 6'b011000, 0, 1);
    check("len_str_stall", 32'(q.size()), 32'd5);
    run_queue();
    run_instr(2'b10, 6'b000000, 0, 0);
    check("len_b", 32'(q.size()), 32'd3);
    run_queue();
    run_instr(2'b11, 6'b000000, 0, 0);
    run_instr(2'b01, 6'b011001, 0, 0);
    check("len_und_ldr", 32'(q.size()), 32'd8);
    run_queue();

    // Park in MEMRD, then reset asynchronously mid-cycle.
    cur_op = 2'b01; cur_funct = 6'b011001;
    push("FETCH", 1'b1, 1); push("DECODE", 1'b0, 0); push("MEMADR", 1'b0, 0);
    push("MEMRD", 1'b0, 1); push("MEMRD", 1'b0, 1);
    run_queue();
    reset_mid_cycle_checks("rst_memrd");

    cur_op = 2'b01; cur_funct = 6'b011000;
    push("FETCH", 1'b1, 1); push("DECODE", 1'b0, 0); push("MEMADR", 1'b0, 0);
    push("MEMWR", 1'b0, 1);
    run_queue();
    reset_mid_cycle_checks("rst_memwr");

    run_instr(2'b00, 6'b001000, 0, 0);
    run_queue();

`ifdef MC_FSM_PERF_EN
    reset = 1'b1;
    #2;
    check("perf_rst_cyc", 32'(CycCnt), 32'd0);
    check("perf_rst_ret", 32'(InstRet), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) run_instr(2'b00, 6'b001000, 0, 0);
    run_queue();
    check("perf_cyc16", 32'(CycCnt), 32'd16);
    check("perf_ret4", 32'(InstRet), 32'd4);
    for (int i = 0; i < 3; i++) run_instr(2'b00, 6'b001000, 0, 0);
    run_instr(2'b11, 6'b000000, 0, 0);
    run_queue();
    check("perf_cyc_max", 32'(CycCnt), 32'd31);
    check("perf_ret_no_und", 32'(InstRet), 32'd7);
    run_instr(2'b00, 6'b001000, 0, 0);
    run_queue();
    check("perf_cyc_wrap", 32'(CycCnt), 32'd3);
    check("perf_ret8", 32'(InstRet), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
